// File: rtl/sample_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// sample_buffer_ctrl
//
// Purpose: sequences a single-port sample RAM for two jobs. In record mode it
// streams ADC samples into the RAM starting at address 0. In play mode it
// streams the recorded samples back out to a DAC through a valid/ready
// handshake, and can optionally loop over the recording.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous, active-low reset
//   start_record one-cycle command: begin capture at address 0
//   start_play   one-cycle command: begin playback from address 0
//   stop         one-cycle command: abort the current mode
//   loop_en      when high, playback restarts at address 0 after the last sample
//   adc_valid    adc_data carries a new sample this cycle
//   adc_data     ADC sample
//   dac_ready    DAC accepts dac_data this cycle
//   dac_valid    dac_data carries a playback sample
//   dac_data     playback sample
//   ram_addr     RAM address
//   ram_we       RAM write strobe
//   ram_wdata    RAM write data
//   ram_rdata    RAM read data, valid one clock after ram_addr is sampled
//   mode         0 idle, 1 record, 2 play
//   rec_len      number of samples stored by the last/current recording
//   rec_full     the last recording filled the whole buffer
// -----------------------------------------------------------------------------
module sample_buffer_ctrl #(
  parameter int data_size = 32,
  parameter int addr_size = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start_record,
  input  logic                 start_play,
  input  logic                 stop,
  input  logic                 loop_en,
  input  logic                 adc_valid,
  input  logic [data_size-1:0] adc_data,
  input  logic                 dac_ready,
  output logic                 dac_valid,
  output logic [data_size-1:0] dac_data,
  output logic [addr_size-1:0] ram_addr,
  output logic                 ram_we,
  output logic [data_size-1:0] ram_wdata,
  input  logic [data_size-1:0] ram_rdata,
  output logic [1:0]           mode,
  output logic [addr_size:0]   rec_len,
  output logic                 rec_full
);

  typedef enum logic [2:0] {
    IDLE,
    RECORD,
    PLAY_ADDR,
    PLAY_WAIT,
    PLAY_OUT
  } state_t;

  localparam logic [1:0]           ModeIdle   = 2'd0;
  localparam logic [1:0]           ModeRecord = 2'd1;
  localparam logic [1:0]           ModePlay   = 2'd2;
  localparam logic [addr_size-1:0] PtrOne     = {{(addr_size-1){1'b0}}, 1'b1};
  localparam logic [addr_size-1:0] PtrMax     = {addr_size{1'b1}};
  localparam logic [addr_size:0]   LenOne     = {{addr_size{1'b0}}, 1'b1};

  state_t                 state_q,     state_d;
  logic [addr_size-1:0]   wrPtr_q,     wrPtr_d;
  logic [addr_size-1:0]   rdPtr_q,     rdPtr_d;
  logic [addr_size:0]     recLen_q,    recLen_d;
  logic                   recFull_q,   recFull_d;
  logic [addr_size-1:0]   ramAddr_q,   ramAddr_d;
  logic                   ramWe_q,     ramWe_d;
  logic [data_size-1:0]   ramWdata_q,  ramWdata_d;
  logic                   dacValid_q,  dacValid_d;
  logic [data_size-1:0]   dacData_q,   dacData_d;
  logic [1:0]             mode_q,      mode_d;

  logic                   lastSample;

  // The read pointer is one bit narrower than rec_len, so zero-extend it
  // before comparing against the last stored index.
  assign lastSample = ({1'b0, rdPtr_q} == (recLen_q - LenOne));

  // State and output registers. Every output comes straight from a flop; the
  // reset is asynchronous so a pending write or DAC transfer is dropped at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      recLen_q   <= '0;
      recFull_q  <= 1'b0;
      ramAddr_q  <= '0;
      ramWe_q    <= 1'b0;
      ramWdata_q <= '0;
      dacValid_q <= 1'b0;
      dacData_q  <= '0;
      mode_q     <= ModeIdle;
    end else begin
      state_q    <= state_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      recLen_q   <= recLen_d;
      recFull_q  <= recFull_d;
      ramAddr_q  <= ramAddr_d;
      ramWe_q    <= ramWe_d;
      ramWdata_q <= ramWdata_d;
      dacValid_q <= dacValid_d;
      dacData_q  <= dacData_d;
      mode_q     <= mode_d;
    end
  end

  // Next-state logic. Everything holds by default except the write strobe,
  // which is a single-cycle pulse. stop is checked first in every state so it
  // always beats a start command or a DAC accept arriving in the same cycle.
  always_comb begin
    state_d    = state_q;
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    recLen_d   = recLen_q;
    recFull_d  = recFull_q;
    ramAddr_d  = ramAddr_q;
    ramWe_d    = 1'b0;
    ramWdata_d = ramWdata_q;
    dacValid_d = dacValid_q;
    dacData_d  = dacData_q;

    case (state_q)
      IDLE: begin
        if (!stop) begin
          if (start_record) begin
            state_d   = RECORD;
            wrPtr_d   = '0;
            recLen_d  = '0;
            recFull_d = 1'b0;
          end else if (start_play && (recLen_q != '0)) begin
            state_d   = PLAY_ADDR;
            rdPtr_d   = '0;
            ramAddr_d = '0;
          end
        end
      end

      RECORD: begin
        if (stop) begin
          state_d = IDLE;
        end else if (adc_valid) begin
          ramWe_d    = 1'b1;
          ramAddr_d  = wrPtr_q;
          ramWdata_d = adc_data;
          recLen_d   = recLen_q + LenOne;
          // The top address ends the recording; the write pointer parks
          // there rather than wrapping back onto sample 0.
          if (wrPtr_q == PtrMax) begin
            recFull_d = 1'b1;
            state_d   = IDLE;
          end else begin
            wrPtr_d = wrPtr_q + PtrOne;
          end
        end
      end

      // ram_addr was loaded on the way in; this cycle lets the RAM sample it.
      PLAY_ADDR: begin
        if (stop) begin
          state_d = IDLE;
        end else begin
          state_d = PLAY_WAIT;
        end
      end

      PLAY_WAIT: begin
        if (stop) begin
          state_d = IDLE;
        end else begin
          state_d    = PLAY_OUT;
          dacData_d  = ram_rdata;
          dacValid_d = 1'b1;
        end
      end

      PLAY_OUT: begin
        if (stop) begin
          state_d    = IDLE;
          dacValid_d = 1'b0;
        end else if (dac_ready) begin
          dacValid_d = 1'b0;
          if (!lastSample) begin
            state_d   = PLAY_ADDR;
            rdPtr_d   = rdPtr_q + PtrOne;
            ramAddr_d = rdPtr_q + PtrOne;
          end else if (loop_en) begin
            state_d   = PLAY_ADDR;
            rdPtr_d   = '0;
            ramAddr_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d    = IDLE;
        dacValid_d = 1'b0;
      end
    endcase

    // mode follows the state being entered so it is registered alongside it.
    case (state_d)
      RECORD:                        mode_d = ModeRecord;
      PLAY_ADDR, PLAY_WAIT, PLAY_OUT: mode_d = ModePlay;
      default:                       mode_d = ModeIdle;
    endcase
  end

  assign dac_valid = dacValid_q;
  assign dac_data  = dacData_q;
  assign ram_addr  = ramAddr_q;
  assign ram_we    = ramWe_q;
  assign ram_wdata = ramWdata_q;
  assign mode      = mode_q;
  assign rec_len   = recLen_q;
  assign rec_full  = recFull_q;

endmodule

// File: tb/tb_sample_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sample_buffer_ctrl
//
// Purpose: directed self-checking bench for sample_buffer_ctrl. A small
// behavioural RAM with one clock of read latency sits on the RAM port.
// Stimulus is driven 1 time unit after each rising edge and outputs are
// compared at that same point, away from the active edge.
// -----------------------------------------------------------------------------
module tb_sample_buffer_ctrl;

  localparam int DW = 32;
  localparam int AW = 16;

  logic          clock;
  logic          reset;
  logic          startRecord;
  logic          startPlay;
  logic          stopCmd;
  logic          loopEn;
  logic          adcValid;
  logic [DW-1:0] adcData;
  logic          dacReady;
  logic          dacValid;
  logic [DW-1:0] dacData;
  logic [AW-1:0] ramAddr;
  logic          ramWe;
  logic [DW-1:0] ramWdata;
  logic [DW-1:0] ramRdata;
  logic [1:0]    mode;
  logic [AW:0]   recLen;
  logic          recFull;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  sample_buffer_ctrl #(.data_size(DW), .addr_size(AW)) dut (
    .clock       (clock),
    .reset       (reset),
    .start_record(startRecord),
    .start_play  (startPlay),
    .stop        (stopCmd),
    .loop_en     (loopEn),
    .adc_valid   (adcValid),
    .adc_data    (adcData),
    .dac_ready   (dacReady),
    .dac_valid   (dacValid),
    .dac_data    (dacData),
    .ram_addr    (ramAddr),
    .ram_we      (ramWe),
    .ram_wdata   (ramWdata),
    .ram_rdata   (ramRdata),
    .mode        (mode),
    .rec_len     (recLen),
    .rec_full    (recFull)
  );

  // Free-running clock, 10 time unit period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Synchronous RAM model: write on strobe, registered read of ram_addr.
  always @(posedge clock) begin
    if (ramWe) mem[ramAddr] <= ramWdata;
    ramRdata <= mem[ramAddr];
  end

  // Drive one cycle's worth of inputs and advance past the next rising edge.
  task automatic applyStimulus(input logic sr, input logic sp, input logic st,
                               input logic av, input logic [DW-1:0] ad,
                               input logic dr);
    startRecord = sr;
    startPlay   = sp;
    stopCmd     = st;
    adcValid    = av;
    adcData     = ad;
    dacReady    = dr;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset       = 1'b0;
    startRecord = 1'b0;
    startPlay   = 1'b0;
    stopCmd     = 1'b0;
    loopEn      = 1'b0;
    adcValid    = 1'b0;
    adcData     = '0;
    dacReady    = 1'b0;

    // Reset values while reset is held low.
    repeat (2) @(posedge clock);
    #1;
    checkOutput("rst_mode",    64'(mode),     64'd0);
    checkOutput("rst_ram_we",  64'(ramWe),    64'd0);
    checkOutput("rst_addr",    64'(ramAddr),  64'd0);
    checkOutput("rst_wdata",   64'(ramWdata), 64'd0);
    checkOutput("rst_dvalid",  64'(dacValid), 64'd0);
    checkOutput("rst_ddata",   64'(dacData),  64'd0);
    checkOutput("rst_rec_len", 64'(recLen),   64'd0);
    checkOutput("rst_full",    64'(recFull),  64'd0);
    reset = 1'b1;

    // start_play with nothing recorded is ignored; adc_valid in IDLE is ignored.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("play_empty_mode", 64'(mode), 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h77, 1'b0);
    checkOutput("idle_adc_we", 64'(ramWe), 64'd0);

    // Record 0xA0..0xA3 with a gap cycle after each sample.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("rec_mode",    64'(mode),   64'd1);
    checkOutput("rec_len0",    64'(recLen), 64'd0);
    checkOutput("rec_we_idle", 64'(ramWe),  64'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'hA0 + 32'(i), 1'b0);
      checkOutput("rec_we",    64'(ramWe),    64'd1);
      checkOutput("rec_addr",  64'(ramAddr),  64'(i));
      checkOutput("rec_wdata", 64'(ramWdata), 64'(32'hA0 + 32'(i)));
      checkOutput("rec_len",   64'(recLen),   64'(i + 1));
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput("rec_gap_we",   64'(ramWe), 64'd0);
      checkOutput("rec_gap_mode", 64'(mode),  64'd1);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("rec_stop_mode", 64'(mode),    64'd0);
    checkOutput("rec_stop_len",  64'(recLen),  64'd4);
    checkOutput("rec_stop_full", 64'(recFull), 64'd0);

    // Play 4 samples, DAC always ready, no looping.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("play_mode",   64'(mode),     64'd2);
    checkOutput("play_valid0", 64'(dacValid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("play_wait_valid", 64'(dacValid), 64'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("play_valid", 64'(dacValid), 64'd1);
      checkOutput("play_data",  64'(dacData),  64'(32'hA0 + 32'(i)));
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("play_acc_valid", 64'(dacValid), 64'd0);
      checkOutput("play_acc_mode",  64'(mode),     (i == 3) ? 64'd0 : 64'd2);
    end

    // Play again with the DAC stalling for 5 cycles on sample 2.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput("stall_valid", 64'(dacValid), 64'd1);
      checkOutput("stall_data",  64'(dacData),  64'(32'hA0 + 32'(i)));
      if (i == 2) begin
        for (int s = 0; s < 5; s++) begin
          applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
          checkOutput("stall_hold_valid", 64'(dacValid), 64'd1);
          checkOutput("stall_hold_data",  64'(dacData),  64'h0A2);
        end
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("stall_acc_valid", 64'(dacValid), 64'd0);
    end
    checkOutput("stall_end_mode", 64'(mode), 64'd0);

    // Re-record two samples, then loop playback and stop while the DAC is ready.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'hA0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'hA1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("rec2_len",     64'(recLen), 64'd2);
    checkOutput("rec2_stop_we", 64'(ramWe),  64'd0);
    loopEn = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("loop_valid", 64'(dacValid), 64'd1);
      checkOutput("loop_data",  64'(dacData),  64'(32'hA0 + 32'(k % 2)));
      if (k < 5) begin
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("loop_acc_mode", 64'(mode), 64'd2);
      end else begin
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("loop_stop_valid", 64'(dacValid), 64'd0);
        checkOutput("loop_stop_mode",  64'(mode),     64'd0);
        checkOutput("loop_stop_len",   64'(recLen),   64'd2);
      end
    end
    loopEn = 1'b0;

    // start_record and start_play together: record wins.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("both_mode", 64'(mode),   64'd1);
    checkOutput("both_len",  64'(recLen), 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("both_stop_mode", 64'(mode), 64'd0);
    // stop beats start_record in IDLE.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("stop_vs_rec_mode", 64'(mode), 64'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("play_len0_mode", 64'(mode), 64'd0);

    // Reset during RECORD while a write strobe is out.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h55, 1'b0);
    checkOutput("rrec_we_pre", 64'(ramWe), 64'd1);
    reset = 1'b0;
    #1;
    checkOutput("rrec_we",    64'(ramWe),    64'd0);
    checkOutput("rrec_wdata", 64'(ramWdata), 64'd0);
    checkOutput("rrec_mode",  64'(mode),     64'd0);
    checkOutput("rrec_len",   64'(recLen),   64'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h66, 1'b0);
    checkOutput("rrec_after_mode", 64'(mode),  64'd0);
    checkOutput("rrec_after_we",   64'(ramWe), 64'd0);

    // Reset during PLAY_OUT.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'hA0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'hA1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("rplay_valid_pre", 64'(dacValid), 64'd1);
    checkOutput("rplay_data_pre",  64'(dacData),  64'h0A0);
    reset = 1'b0;
    #1;
    checkOutput("rplay_valid", 64'(dacValid), 64'd0);
    checkOutput("rplay_data",  64'(dacData),  64'd0);
    checkOutput("rplay_mode",  64'(mode),     64'd0);
    checkOutput("rplay_len",   64'(recLen),   64'd0);
    checkOutput("rplay_addr",  64'(ramAddr),  64'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("rplay_after_mode",  64'(mode),     64'd0);
    checkOutput("rplay_after_valid", 64'(dacValid), 64'd0);

    // Fill the whole buffer with adc_valid held high.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < (1 << AW); i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'hC000_0000 | 32'(i), 1'b0);
      checkOutput("full_we",   64'(ramWe),   64'd1);
      checkOutput("full_addr", 64'(ramAddr), 64'(i));
      if (i == 0 || i == (1 << AW) - 2) begin
        checkOutput("full_wdata", 64'(ramWdata), 64'(32'hC000_0000 | 32'(i)));
        checkOutput("full_len",   64'(recLen),   64'(i + 1));
        checkOutput("full_mode",  64'(mode),     64'd1);
        checkOutput("full_flag0", 64'(recFull),  64'd0);
      end
    end
    checkOutput("full_end_len",  64'(recLen),  64'd65536);
    checkOutput("full_end_flag", 64'(recFull), 64'd1);
    checkOutput("full_end_mode", 64'(mode),    64'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_0000, 1'b0);
      checkOutput("full_after_we",   64'(ramWe),   64'd0);
      checkOutput("full_after_addr", 64'(ramAddr), 64'hFFFF);
    end
    checkOutput("full_mem0", 64'(mem[0]), 64'hC000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sample_buffer_ctrl.md
SAMPLE_BUFFER_CTRL -- requirements
Module: sample_buffer_ctrl

Interface
REQ-001 Parameter: data_size, 32, sample width in bits.
REQ-002 Parameter: addr_size, 16, RAM address width; buffer depth 2^addr_size.
REQ-003 Port: clock  input  1  rising-edge clock.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: start_record  input  1  one-cycle command, begin capture at address 0.
REQ-006 Port: start_play  input  1  one-cycle command, begin playback from address 0.
REQ-007 Port: stop  input  1  one-cycle command, abort current mode.
REQ-008 Port: loop_en  input  1  playback restarts at address 0 after last sample.
REQ-009 Port: adc_valid  input  1  adc_data holds a new sample this cycle.
REQ-010 Port: adc_data  input  data_size  ADC sample.
REQ-011 Port: dac_ready  input  1  DAC accepts dac_data this cycle.
REQ-012 Port: dac_valid  output  1  dac_data holds a playback sample.
REQ-013 Port: dac_data  output  data_size  playback sample.
REQ-014 Port: ram_addr  output  addr_size  RAM address.
REQ-015 Port: ram_we  output  1  RAM write strobe.
REQ-016 Port: ram_wdata  output  data_size  RAM write data.
REQ-017 Port: ram_rdata  input  data_size  RAM read data, valid one clock after ram_addr sampled.
REQ-018 Port: mode  output  2  0 idle, 1 record, 2 play.
REQ-019 Port: rec_len  output  addr_size+1  samples stored by last/current recording (0..2^addr_size).
REQ-020 Port: rec_full  output  1  last recording filled the buffer.

Function
REQ-021 FSM states SHALL be IDLE, RECORD, PLAY_ADDR, PLAY_WAIT, PLAY_OUT; mode = 1 in RECORD, 2 in any PLAY_* state, 0 in IDLE.
REQ-022 All outputs SHALL be registered.
REQ-023 Priority SHALL be stop > start_record > start_play; start commands outside IDLE SHALL be ignored.
REQ-024 IDLE + start_record: next state RECORD; wr_ptr, rec_len, rec_full cleared to 0 on the same edge.
REQ-025 RECORD + adc_valid at edge N: after edge N, ram_we=1, ram_addr=wr_ptr, ram_wdata=adc_data for exactly one cycle; wr_ptr and rec_len increment on edge N.
REQ-026 RECORD without adc_valid: ram_we=0; adc_valid outside RECORD SHALL be ignored.
REQ-027 Write issued to address 2^addr_size-1: rec_len=2^addr_size, rec_full=1, state returns to IDLE on the same edge; wr_ptr SHALL NOT wrap.
REQ-028 stop in RECORD: state IDLE next edge, ram_we=0, rec_len retained; a write strobed on the stop edge's prior cycle completes normally.
REQ-029 IDLE + start_play with rec_len=0: ignored, remain IDLE.
REQ-030 IDLE + start_play with rec_len>0: rd_ptr=0, state PLAY_ADDR, ram_addr=rd_ptr, ram_we=0.
REQ-031 PLAY_ADDR -> PLAY_WAIT unconditionally; PLAY_WAIT -> PLAY_OUT with dac_data latched from ram_rdata and dac_valid=1.
REQ-032 dac_valid SHALL be 1 exactly 3 cycles after the start_play sampling edge (also 3 cycles after each accepted sample to the next).
REQ-033 PLAY_OUT: dac_valid and dac_data SHALL hold stable until dac_ready=1; on that edge dac_valid clears.
REQ-034 Accept with rd_ptr<rec_len-1: rd_ptr+1, go PLAY_ADDR.
REQ-035 Accept with rd_ptr=rec_len-1: loop_en=1 -> rd_ptr=0, PLAY_ADDR; loop_en=0 -> IDLE.
REQ-036 stop in any PLAY_* state: IDLE next edge, dac_valid=0 even if dac_ready asserted same cycle (sample counted as not delivered).
REQ-037 rec_len and rec_full SHALL persist through playback and stop; only start_record or reset clears them.

Reset
REQ-038 reset low SHALL immediately force IDLE, wr_ptr=rd_ptr=0, ram_addr=0, ram_we=0, ram_wdata=0, dac_valid=0, dac_data=0, mode=0, rec_len=0, rec_full=0.
REQ-039 Reset mid-record or mid-playback SHALL abort without completing any pending write or DAC transfer; operation resumes only via a new start command after reset deasserts.

Verification
REQ-040 Record 4 samples 0xA0..0xA3 with gaps in adc_valid -> four one-cycle ram_we pulses at addresses 0..3 with matching data, rec_len=4, mode stays 1 until stop.
REQ-041 Play 4 samples, dac_ready always 1, loop_en=0 -> dac_data 0xA0..0xA3, first dac_valid 3 cycles after start_play, mode returns 0.
REQ-042 Play with dac_ready held low 5 cycles on sample 2 -> dac_valid and dac_data=0xA2 stable throughout, no skipped or repeated samples.
REQ-043 loop_en=1, rec_len=2 -> sequence 0xA0,0xA1,0xA0,0xA1... until stop; stop with dac_ready=1 -> dac_valid=0 next cycle, mode=0.
REQ-044 Record with adc_valid constantly high from start -> 65536 writes, addresses 0..65535, rec_full=1, rec_len=65536, IDLE, no write to address 0 afterwards.
REQ-045 Reset asserted during RECORD and during PLAY_OUT; start_play with rec_len=0; start_record and start_play same cycle -> all outputs at reset values; play ignored; record wins.
